// File: rtl/relprime_sequencer.sv
// relprime_sequencer: finds the smallest m >= M_START with gcd(n, m) == 1.
// Euclid by repeated subtraction, one subtraction per cycle; the candidate m
// is sequenced internally and bumped after each failed gcd.
// Optional build macro: RELPRIME_CYCLE_COUNT_EN adds a 32-bit busy-cycle
// counter on output port 'cycles'.
module relprime_sequencer #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] M_START = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] register_value,
    output logic             busy,
    output logic             done,
    output logic             error,
`ifdef RELPRIME_CYCLE_COUNT_EN
    output logic [31:0]      cycles,
`endif
    output logic [WIDTH-1:0] out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GCD   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             accept;

    assign accept = (state_q == S_IDLE) && start;

    // State and datapath registers; reset clears everything so nothing partial leaks out
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = (n_q == ZERO) ? S_DONE : S_GCD;
            S_GCD:   if (a_q == b_q) state_d = S_CHECK;
            S_CHECK: begin
                if (a_q == ONE)       state_d = S_DONE;
                else if (m_q == ONES) state_d = S_DONE;
                else                  state_d = S_LOAD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Subtract/compare datapath; the a/b compare selects the direction so
    // the unsigned subtraction never underflows
    always_comb begin
        n_d   = n_q;
        m_d   = m_q;
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = register_value;
                    m_d   = M_START;
                    out_d = '0;
                    err_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (n_q == ZERO) begin
                    err_d = 1'b1;      // gcd(0, m) = m, never 1
                end else begin
                    a_d = n_q;
                    b_d = m_q;
                end
            end
            S_GCD: begin
                if (a_q > b_q)      a_d = a_q - b_q;
                else if (a_q < b_q) b_d = b_q - a_q;
            end
            S_CHECK: begin
                if (a_q == ONE)       out_d = m_q;
                else if (m_q == ONES) err_d = 1'b1;   // candidate would wrap
                else                  m_d   = m_q + ONE;
            end
            default: ;
        endcase
    end

`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Busy-cycle counter. The accepting edge loads 1 so the count tracks the
    // busy cycle being entered; DONE is therefore already included while
    // done is high, and the value freezes on return to IDLE.
    always_comb begin
        cyc_d = cyc_q;
        if (accept)
            cyc_d = 32'd1;
        else if ((state_q != S_IDLE) && (state_d != S_IDLE) && (cyc_q != 32'hFFFF_FFFF))
            cyc_d = cyc_q + 32'd1;
    end

    // Counter register
    always_ff @(posedge CLK) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign cycles = cyc_q;
`endif

    assign error = err_q;
    assign out   = out_q;

endmodule
